boot_stream_sequencer: RTL and testbench

BOOT_STREAM_SEQUENCER -- requirements
Module: boot_stream_sequencer

---
 rtl/boot_stream_sequencer.sv | 179 +++++++++++++++++
 tb/tb_boot_stream_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_stream_sequencer.sv
// Host boot-word to byte-stream sequencer with size-bounded unpacking.
// Optional BOOTSEQ_SYNC_EN: drop bytes ahead of the first 0x4E marker.
module boot_stream_sequencer #(
  parameter int BYTE_ORDER_MSB = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] host_bootdata,
  input  logic        host_bootdata_req,
  output logic        host_bootdata_ack,
  input  logic [31:0] rom_size,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] bytes_loaded,
  output logic        done
);

  localparam logic [2:0] S_WAIT_REQ = 3'd0;
  localparam logic [2:0] S_ACK      = 3'd1;
  localparam logic [2:0] S_WAIT_REL = 3'd2;
  localparam logic [2:0] S_UNPACK   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        captured_q, captured_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] size_q, size_d;
  logic        size_vld_q, size_vld_d;
  logic [31:0] bytes_q, bytes_d;
  logic        done_q, done_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        synced;
  logic        synced_set;

  logic [31:0] eff_size;
  logic [1:0]  lane;
  logic [31:0] shifted;
  logic [7:0]  cur_byte;
  logic        emit_ok;

`ifdef BOOTSEQ_SYNC_EN
  logic synced_q, synced_d;
  always_ff @(posedge clk) begin
    if (reset) synced_q <= 1'b0;
    else       synced_q <= synced_d;
  end
  always_comb begin
    synced_d = synced_q | synced_set;
  end
  assign synced = synced_q;
`else
  assign synced = 1'b1;
`endif

  always_comb begin
    // Until the first word arrives, the live rom_size is the bound.
    eff_size = size_vld_q ? size_q : rom_size;
    lane     = (BYTE_ORDER_MSB != 0) ? ~idx_q : idx_q;
    shifted  = word_q >> {lane, 3'b000};
    cur_byte = shifted[7:0];
    emit_ok  = synced | (cur_byte == 8'h4E);
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    captured_d  = captured_q;
    idx_d       = idx_q;
    size_d      = size_q;
    size_vld_d  = size_vld_q;
    bytes_d     = bytes_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    synced_set  = 1'b0;
    done_d      = done_q | (size_vld_q & (bytes_q >= size_q));

    unique case (state_q)
      S_WAIT_REQ: begin
        if (host_bootdata_req) begin
          state_d = S_ACK;
          if (!size_vld_q) begin
            size_vld_d = 1'b1;
            size_d     = rom_size;
          end
          if (bytes_q < eff_size) begin
            word_d     = host_bootdata;
            captured_d = 1'b1;
            idx_d      = 2'd0;
          end else begin
            captured_d = 1'b0;
          end
        end
      end
      S_ACK: begin
        state_d = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!host_bootdata_req) begin
          if (captured_q)  state_d = S_UNPACK;
          else if (done_q) state_d = S_DONE;
          else             state_d = S_WAIT_REQ;
        end
      end
      S_UNPACK: begin
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            bytes_d     = bytes_q + 32'd1;
            idx_d       = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d    = S_WAIT_REQ;
              captured_d = 1'b0;
            end
          end
        end else if (bytes_q >= size_q) begin
          state_d    = S_WAIT_REQ;
          captured_d = 1'b0;
        end else if (emit_ok) begin
          out_valid_d = 1'b1;
          out_data_d  = cur_byte;
          synced_set  = 1'b1;
        end else begin
          // Pre-sync byte: counted, never offered.
          bytes_d = bytes_q + 32'd1;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d    = S_WAIT_REQ;
            captured_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (host_bootdata_req) begin
          state_d    = S_ACK;
          captured_d = 1'b0;
        end
      end
      default: begin
        state_d = S_WAIT_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT_REQ;
      word_q      <= 32'd0;
      captured_q  <= 1'b0;
      idx_q       <= 2'd0;
      size_q      <= 32'd0;
      size_vld_q  <= 1'b0;
      bytes_q     <= 32'd0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      captured_q  <= captured_d;
      idx_q       <= idx_d;
      size_q      <= size_d;
      size_vld_q  <= size_vld_d;
      bytes_q     <= bytes_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign host_bootdata_ack = (state_q == S_ACK);
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign bytes_loaded      = bytes_q;
  assign done              = done_q;

endmodule

// File: tb/tb_boot_stream_sequencer.sv
// Directed bench for boot_stream_sequencer.
// Expected streams are hand-derived from the word/size vectors.
module tb_boot_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic [31:0] rom_size;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] bytes_loaded;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt = 0;
  int viol_cnt = 0;
  int a0;

  always #5 clk = ~clk;

  boot_stream_sequencer #(.BYTE_ORDER_MSB(1)) dut (
    .clk(clk),
    .reset(reset),
    .host_bootdata(host_bootdata),
    .host_bootdata_req(host_bootdata_req),
    .host_bootdata_ack(host_bootdata_ack),
    .rom_size(rom_size),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bytes_loaded(bytes_loaded),
    .done(done)
  );

  always @(posedge clk) begin
    if (!reset && host_bootdata_ack) ack_cnt <= ack_cnt + 1;
    if (host_bootdata_ack && out_valid) viol_cnt <= viol_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    host_bootdata_req = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic host_word(input logic [31:0] w);
    int n = 0;
    host_bootdata = w;
    host_bootdata_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!host_bootdata_ack && n < 30);
    chk("ack_seen", {31'd0, host_bootdata_ack}, 32'd1);
    host_bootdata_req = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] exp, input int off);
    int n = 0;
    out_ready = (off == 0);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_valid", {31'd0, out_valid}, 32'd1);
    chk("byte_data", {24'd0, out_data}, {24'd0, exp});
    for (int i = 0; i < off; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {24'd0, out_data}, {24'd0, exp});
      chk("hold_noack", {31'd0, host_bootdata_ack}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = (off == 0);
  endtask

  initial begin
    reset = 1'b1;
    host_bootdata = 32'd0;
    host_bootdata_req = 1'b0;
    rom_size = 32'd8;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, host_bootdata_ack}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_bytes", bytes_loaded, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Full 8-byte image, ready always high
    a0 = ack_cnt;
    host_word(32'h4E45531A);
    expect_byte(8'h4E, 0);
    expect_byte(8'h45, 0);
    expect_byte(8'h53, 0);
    expect_byte(8'h1A, 0);
    host_word(32'h01020304);
    expect_byte(8'h01, 0);
    expect_byte(8'h02, 0);
    expect_byte(8'h03, 0);
    expect_byte(8'h04, 0);
    repeat (2) @(negedge clk);
    chk("r29_bytes", bytes_loaded, 32'd8);
    chk("r29_done", {31'd0, done}, 32'd1);
    chk("r29_acks", ack_cnt - a0, 32'd2);

    // Truncated image: size 6
    do_reset();
    rom_size = 32'd6;
    host_word(32'h4E45531A);
    expect_byte(8'h4E, 0);
    expect_byte(8'h45, 0);
    expect_byte(8'h53, 0);
    expect_byte(8'h1A, 0);
    host_word(32'h01020304);
    expect_byte(8'h01, 0);
    expect_byte(8'h02, 0);
    repeat (4) @(negedge clk);
    chk("r30_novalid", {31'd0, out_valid}, 32'd0);
    chk("r30_bytes", bytes_loaded, 32'd6);
    chk("r30_done", {31'd0, done}, 32'd1);
    a0 = ack_cnt;
    host_word(32'h12345678);
    repeat (10) @(negedge clk);
    chk("r30_ack3", ack_cnt - a0, 32'd1);
    chk("r30_novalid3", {31'd0, out_valid}, 32'd0);
    chk("r30_bytes3", bytes_loaded, 32'd6);
    chk("r30_done3", {31'd0, done}, 32'd1);

    // Backpressure: 1 on / 3 off
    do_reset();
    rom_size = 32'd8;
    host_word(32'h4E45531A);
    expect_byte(8'h4E, 3);
    expect_byte(8'h45, 3);
    expect_byte(8'h53, 3);
    expect_byte(8'h1A, 3);
    host_word(32'h01020304);
    expect_byte(8'h01, 3);
    expect_byte(8'h02, 3);
    expect_byte(8'h03, 3);
    expect_byte(8'h04, 3);
    repeat (2) @(negedge clk);
    chk("r31_bytes", bytes_loaded, 32'd8);
    chk("r31_done", {31'd0, done}, 32'd1);

    // Sync marker stream
    do_reset();
    rom_size = 32'd8;
    host_word(32'h00004E45);
`ifndef BOOTSEQ_SYNC_EN
    expect_byte(8'h00, 0);
    expect_byte(8'h00, 0);
`endif
    expect_byte(8'h4E, 0);
    expect_byte(8'h45, 0);
    host_word(32'h531A0000);
    expect_byte(8'h53, 0);
    expect_byte(8'h1A, 0);
    expect_byte(8'h00, 0);
    expect_byte(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("r32_bytes", bytes_loaded, 32'd8);
    chk("r32_done", {31'd0, done}, 32'd1);

    // req held high for 10 cycles
    do_reset();
    rom_size = 32'd4;
    a0 = ack_cnt;
    host_bootdata = 32'hAABBCCDD;
    host_bootdata_req = 1'b1;
    repeat (10) @(negedge clk);
    chk("r33_valid_hold", {31'd0, out_valid}, 32'd0);
    host_bootdata_req = 1'b0;
    chk("r33_acks", ack_cnt - a0, 32'd1);
    expect_byte(8'hAA, 0);
    expect_byte(8'hBB, 0);
    expect_byte(8'hCC, 0);
    expect_byte(8'hDD, 0);
    repeat (4) @(negedge clk);
    chk("r33_bytes", bytes_loaded, 32'd4);
    chk("r33_novalid", {31'd0, out_valid}, 32'd0);
    chk("r33_done", {31'd0, done}, 32'd1);

    // Reset mid-word, then rerun
    do_reset();
    rom_size = 32'd8;
    host_word(32'h4E45531A);
    expect_byte(8'h4E, 0);
    expect_byte(8'h45, 0);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("r34_valid", {31'd0, out_valid}, 32'd0);
    chk("r34_bytes", bytes_loaded, 32'd0);
    chk("r34_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    rom_size = 32'd4;
    host_word(32'hAABBCCDD);
    expect_byte(8'hAA, 0);
    expect_byte(8'hBB, 0);
    expect_byte(8'hCC, 0);
    expect_byte(8'hDD, 0);
    repeat (2) @(negedge clk);
    chk("r34_done2", {31'd0, done}, 32'd1);
    chk("r34_bytes2", bytes_loaded, 32'd4);

    // Zero-size image
    do_reset();
    rom_size = 32'd0;
    host_word(32'h11223344);
    chk("r23_done_at_ack", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("r23_done", {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
    chk("r23_novalid", {31'd0, out_valid}, 32'd0);
    chk("r23_bytes", bytes_loaded, 32'd0);

    chk("ack_vs_valid", viol_cnt, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
